// File: rtl/fft_pkg.sv
// Shared FFT definitions: geometry, FSM/stage encodings and the stage permutation.
// The input redistribution stage uses stage_index too, so the map lives only here.
package fft_pkg;

    localparam int NUM_VEC  = 8;
    localparam int NUM_LANE = 4;
    localparam int NUM_PT   = 32;

    localparam logic [1:0] STG_STRIDE8 = 2'd0;
    localparam logic [1:0] STG_PAIR    = 2'd1;
    localparam logic [1:0] STG_BLOCK4  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } collector_state_e;

    function automatic logic [4:0] stage_index(input logic [1:0] stage, input int v, input int j);
        int idx;
        case (stage)
            STG_STRIDE8: idx = v + 8 * j;
            STG_PAIR:    idx = 8 * (v >> 1) + 2 * j + (v & 1);
            default:     idx = 4 * v + j;
        endcase
        return idx[4:0];
    endfunction

endpackage

// File: rtl/fft_result_collector_bank.sv
// 32-point complex result bank; one beat rewrites every entry through the stage map.
// Write lands on the accepting edge and is visible on the packed outputs next cycle.
module collector_bank
    import fft_pkg::*;
#(
    parameter int formatWidth = 9
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    we,
    input  logic [1:0]                              stage,
    input  logic [NUM_VEC-1:0][formatWidth*4-1:0]   vec_real,
    input  logic [NUM_VEC-1:0][formatWidth*4-1:0]   vec_imag,
    output logic [formatWidth*NUM_PT-1:0]           out_real,
    output logic [formatWidth*NUM_PT-1:0]           out_imag
);

    logic [formatWidth-1:0] bank_real [NUM_PT];
    logic [formatWidth-1:0] bank_imag [NUM_PT];

    // Lane 0 sits in the most significant slot of each vector word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < NUM_PT; n++) begin
                bank_real[n] <= '0;
                bank_imag[n] <= '0;
            end
        end else if (we) begin
            for (int v = 0; v < NUM_VEC; v++) begin
                for (int j = 0; j < NUM_LANE; j++) begin
                    bank_real[stage_index(stage, v, j)] <= vec_real[v][(3-j)*formatWidth +: formatWidth];
                    bank_imag[stage_index(stage, v, j)] <= vec_imag[v][(3-j)*formatWidth +: formatWidth];
                end
            end
        end
    end

    always_comb begin
        out_real = '0;
        out_imag = '0;
        for (int n = 0; n < NUM_PT; n++) begin
            out_real[n*formatWidth +: formatWidth] = bank_real[n];
            out_imag[n*formatWidth +: formatWidth] = bank_imag[n];
        end
    end

endmodule

// File: rtl/fft_result_collector.sv
// Collects 1-3 vector-unit beats into the result bank, then presents the 32-point result.
// One beat per cycle while collecting; result held on out_valid until out_ready, start aborts.
module fft_result_collector
    import fft_pkg::*;
#(
    parameter int formatWidth = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [1:0]                    num_stages,
    input  logic                          vec_valid,
    output logic                          vec_ready,
    input  logic [formatWidth*4-1:0]      vector_output_real_0,
    input  logic [formatWidth*4-1:0]      vector_output_real_1,
    input  logic [formatWidth*4-1:0]      vector_output_real_2,
    input  logic [formatWidth*4-1:0]      vector_output_real_3,
    input  logic [formatWidth*4-1:0]      vector_output_real_4,
    input  logic [formatWidth*4-1:0]      vector_output_real_5,
    input  logic [formatWidth*4-1:0]      vector_output_real_6,
    input  logic [formatWidth*4-1:0]      vector_output_real_7,
    input  logic [formatWidth*4-1:0]      vector_output_imag_0,
    input  logic [formatWidth*4-1:0]      vector_output_imag_1,
    input  logic [formatWidth*4-1:0]      vector_output_imag_2,
    input  logic [formatWidth*4-1:0]      vector_output_imag_3,
    input  logic [formatWidth*4-1:0]      vector_output_imag_4,
    input  logic [formatWidth*4-1:0]      vector_output_imag_5,
    input  logic [formatWidth*4-1:0]      vector_output_imag_6,
    input  logic [formatWidth*4-1:0]      vector_output_imag_7,
    output logic                          stage_done,
    output logic [1:0]                    stage_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [formatWidth*NUM_PT-1:0] output_real,
    output logic [formatWidth*NUM_PT-1:0] output_imag
);

    collector_state_e state;
    logic [1:0]       s;
    logic [1:0]       num_lat;
    logic             accept;

    logic [NUM_VEC-1:0][formatWidth*4-1:0] vec_real;
    logic [NUM_VEC-1:0][formatWidth*4-1:0] vec_imag;

    assign vec_real = {vector_output_real_7, vector_output_real_6, vector_output_real_5, vector_output_real_4,
                       vector_output_real_3, vector_output_real_2, vector_output_real_1, vector_output_real_0};
    assign vec_imag = {vector_output_imag_7, vector_output_imag_6, vector_output_imag_5, vector_output_imag_4,
                       vector_output_imag_3, vector_output_imag_2, vector_output_imag_1, vector_output_imag_0};

    // A start in the same cycle as a beat discards the beat.
    assign accept = (state == COLLECT) && vec_valid && !start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            s          <= 2'd0;
            num_lat    <= 2'd1;
            vec_ready  <= 1'b0;
            stage_done <= 1'b0;
            stage_idx  <= 2'd0;
            out_valid  <= 1'b0;
        end else begin
            stage_done <= 1'b0;
            if (start) begin
                state     <= COLLECT;
                s         <= 2'd0;
                num_lat   <= (num_stages == 2'd0) ? 2'd1 : num_stages;
                vec_ready <= 1'b1;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (vec_valid) begin
                            stage_done <= 1'b1;
                            stage_idx  <= s;
                            s          <= s + 2'd1;
                            if (s + 2'd1 == num_lat) begin
                                state     <= PRESENT;
                                vec_ready <= 1'b0;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                    PRESENT: begin
                        if (out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    collector_bank #(.formatWidth(formatWidth)) u_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (accept),
        .stage    (s),
        .vec_real (vec_real),
        .vec_imag (vec_imag),
        .out_real (output_real),
        .out_imag (output_imag)
    );

endmodule

// File: tb/tb_fft_result_collector.sv
module tb_fft_result_collector;

    localparam int W = 9;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     num_stages;
    logic           vec_valid;
    logic           vec_ready;
    logic [4*W-1:0] vr [8];
    logic [4*W-1:0] vi [8];
    logic           stage_done;
    logic [1:0]     stage_idx;
    logic           out_valid;
    logic           out_ready;
    logic [32*W-1:0] output_real;
    logic [32*W-1:0] output_imag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_result_collector #(.formatWidth(W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_stages(num_stages),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vector_output_real_0(vr[0]), .vector_output_real_1(vr[1]),
        .vector_output_real_2(vr[2]), .vector_output_real_3(vr[3]),
        .vector_output_real_4(vr[4]), .vector_output_real_5(vr[5]),
        .vector_output_real_6(vr[6]), .vector_output_real_7(vr[7]),
        .vector_output_imag_0(vi[0]), .vector_output_imag_1(vi[1]),
        .vector_output_imag_2(vi[2]), .vector_output_imag_3(vi[3]),
        .vector_output_imag_4(vi[4]), .vector_output_imag_5(vi[5]),
        .vector_output_imag_6(vi[6]), .vector_output_imag_7(vi[7]),
        .stage_done(stage_done), .stage_idx(stage_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .output_real(output_real), .output_imag(output_imag)
    );

    task automatic chk(input string tag, input logic [32*W-1:0] obs, input logic [32*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element n of the final result holds n + base.
    function automatic logic [32*W-1:0] ramp(input int base);
        logic [32*W-1:0] r;
        r = '0;
        for (int n = 0; n < 32; n++) r[n*W +: W] = W'(n + base);
        return r;
    endfunction

    // Lane values chosen so that the stage map lands element n on n + base.
    task automatic load_beat(input int stage, input int rbase, input int ibase);
        int idx;
        for (int v = 0; v < 8; v++) begin
            for (int j = 0; j < 4; j++) begin
                if (stage == 0)      idx = v + 8 * j;
                else if (stage == 1) idx = 8 * (v / 2) + 2 * j + (v % 2);
                else                 idx = 4 * v + j;
                vr[v][(3-j)*W +: W] = W'(idx + rbase);
                vi[v][(3-j)*W +: W] = W'(idx + ibase);
            end
        end
    endtask

    task automatic load_junk();
        for (int v = 0; v < 8; v++) begin
            vr[v] = 36'({$urandom(), $urandom()});
            vi[v] = 36'({$urandom(), $urandom()});
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; num_stages = 2'd1; vec_valid = 1'b0; out_ready = 1'b0;
        for (int v = 0; v < 8; v++) begin vr[v] = '0; vi[v] = '0; end
        tick(); tick();
        chk("rst_vec_ready", vec_ready, 0);
        chk("rst_stage_done", stage_done, 0);
        chk("rst_stage_idx", stage_idx, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_output_real", output_real, 0);
        chk("rst_output_imag", output_imag, 0);
        rst = 1'b1;

        // vec_valid in IDLE must not write the bank
        load_beat(0, 0, 200); vec_valid = 1'b1;
        tick(); tick();
        vec_valid = 1'b0;
        chk("idle_stage_done", stage_done, 0);
        chk("idle_vec_ready", vec_ready, 0);
        chk("idle_output_real", output_real, 0);

        // Single stage
        num_stages = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_vec_ready_rise", vec_ready, 1);
        chk("s1_out_valid_low", out_valid, 0);
        load_beat(0, 0, 200); vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        chk("s1_stage_done", stage_done, 1);
        chk("s1_stage_idx", stage_idx, 0);
        chk("s1_out_valid", out_valid, 1);
        chk("s1_vec_ready_low", vec_ready, 0);
        chk("s1_real", output_real, ramp(0));
        chk("s1_imag", output_imag, ramp(200));

        // Backpressure with stray beats
        load_junk(); vec_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_vec_ready", vec_ready, 0);
            chk("bp_stage_done", stage_done, 0);
        end
        vec_valid = 1'b0;
        chk("bp_real_stable", output_real, ramp(0));
        chk("bp_imag_stable", output_imag, ramp(200));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_out_valid_drop", out_valid, 0);
        chk("bp_idle_vec_ready", vec_ready, 0);
        chk("bp_real_kept", output_real, ramp(0));

        // Three stages, final beat uses the block-of-4 map
        num_stages = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        load_junk(); vec_valid = 1'b1;
        tick();
        chk("s3_done0", stage_done, 1);
        chk("s3_idx0", stage_idx, 0);
        chk("s3_ov0", out_valid, 0);
        load_junk();
        tick();
        chk("s3_idx1", stage_idx, 1);
        chk("s3_ov1", out_valid, 0);
        load_beat(2, 32, 300);
        tick();
        vec_valid = 1'b0;
        chk("s3_done2", stage_done, 1);
        chk("s3_idx2", stage_idx, 2);
        chk("s3_ov2", out_valid, 1);
        chk("s3_real", output_real, ramp(32));
        chk("s3_imag", output_imag, ramp(300));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("s3_ov_drop", out_valid, 0);
        tick();

        // Abort on a stage-1 beat
        num_stages = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        load_junk(); vec_valid = 1'b1;
        tick();
        chk("ab_idx0", stage_idx, 0);
        load_junk(); start = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_beat_dropped", stage_done, 0);
        chk("ab_vec_ready", vec_ready, 1);
        load_junk();
        tick();
        chk("ab_restart_idx", stage_idx, 0);
        chk("ab_restart_done", stage_done, 1);
        chk("ab_ov_a", out_valid, 0);
        load_junk();
        tick();
        chk("ab_idx1", stage_idx, 1);
        chk("ab_ov_b", out_valid, 0);
        load_beat(2, 64, 350);
        tick();
        vec_valid = 1'b0;
        chk("ab_idx2", stage_idx, 2);
        chk("ab_ov_c", out_valid, 1);
        chk("ab_real", output_real, ramp(64));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ab_ov_drop", out_valid, 0);

        // Async reset after one of three beats
        num_stages = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        load_junk(); vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        chk("ar_done_before", stage_done, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_stage_done", stage_done, 0);
        chk("ar_vec_ready", vec_ready, 0);
        chk("ar_real", output_real, 0);
        chk("ar_imag", output_imag, 0);
        tick();
        rst = 1'b1;

        // Fresh 2-stage transform, final beat uses the pair map
        num_stages = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        load_junk(); vec_valid = 1'b1;
        tick();
        chk("t2_idx0", stage_idx, 0);
        chk("t2_ov0", out_valid, 0);
        load_beat(1, 100, 400);
        tick();
        vec_valid = 1'b0;
        chk("t2_idx1", stage_idx, 1);
        chk("t2_ov1", out_valid, 1);
        chk("t2_real", output_real, ramp(100));
        chk("t2_imag", output_imag, ramp(400));

        // Handshake together with start, num_stages 0 behaves as 1
        out_ready = 1'b1; start = 1'b1; num_stages = 2'd0;
        tick();
        out_ready = 1'b0; start = 1'b0;
        chk("hs_ov_drop", out_valid, 0);
        chk("hs_collect", vec_ready, 1);
        load_beat(0, 7, 450); vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        chk("z_ov", out_valid, 1);
        chk("z_idx", stage_idx, 0);
        chk("z_real", output_real, ramp(7));
        chk("z_imag", output_imag, ramp(450));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_result_collector.md
# fft_result_collector

Gathers the per-stage outputs of the eight 4-lane butterfly vector units and writes them into a 32-entry complex result bank using the inverse of the stage permutation applied on the input side. After the last stage of a transform it presents the full 32-point result in natural index order on a valid/ready output port. It sits between the vector-unit outputs and the FFT core's result interface, opposite the input redistribution stage.

## Interface
- `formatWidth`, default 9: bits per real or imaginary sample.
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle pulse that begins a transform. Clears the stage counter.
- `num_stages`, input, 2: number of vector beats in this transform, 1 to 3. Sampled on `start`. A value of 0 is treated as 1.
- `vec_valid`, input, 1: the vector units present one stage result this cycle.
- `vec_ready`, output, 1: the collector can accept a beat.
- `vector_output_real_0` … `vector_output_real_7`, input, formatWidth*4 each: lane data. Lane j occupies bits [formatWidth*(4-j)-1 : formatWidth*(3-j)], so lane 0 is the most significant slot.
- `vector_output_imag_0` … `vector_output_imag_7`, input, formatWidth*4 each: imaginary lanes, same packing.
- `stage_done`, output, 1: one-cycle pulse after each accepted beat.
- `stage_idx`, output, 2: index of the stage just completed. Valid while `stage_done` is high.
- `out_valid`, output, 1: the final result is available.
- `out_ready`, input, 1: the consumer accepts the result.
- `output_real`, output, formatWidth*32: element n is at bits [formatWidth*(n+1)-1 : formatWidth*n].
- `output_imag`, output, formatWidth*32: same packing.

## Operation
- FSM states: IDLE, COLLECT, PRESENT.
- **IDLE**
  - `vec_ready` = 0.
  - On `start`: latch `num_stages`, set stage counter `s` = 0, go to COLLECT.
- **COLLECT**
  - `vec_ready` = 1.
  - When `vec_valid` is high, write all 64 samples into the bank. Vector v, lane j goes to index idx:
    - `s` = 0: idx = v + 8j.
    - `s` = 1: idx = 8·(v>>1) + 2j + (v&1).
    - `s` = 2: idx = 4v + j.
  - Each write is a full-bank overwrite. Every index 0..31 is written exactly once per beat.
  - Pulse `stage_done` with `stage_idx` = `s`, then increment `s`.
  - If `s` + 1 = `num_stages`, go to PRESENT. Otherwise stay in COLLECT.
- **PRESENT**
  - `out_valid` = 1 and `vec_ready` = 0.
  - `output_*` reflect the bank and stay stable until the handshake.
  - On `out_valid` and `out_ready`: go to IDLE, drop `out_valid` the next cycle.
- `start` in COLLECT or PRESENT aborts the current transform.
  - Restart at `s` = 0 in COLLECT.
  - `out_valid` drops next cycle.
  - Bank contents are retained until overwritten.
- `start` in the same cycle as an accepted beat: `start` wins and the beat is discarded.
- `start` in the same cycle as an output handshake: the handshake completes and the FSM enters COLLECT.
- `vec_valid` while `vec_ready` = 0 is ignored. No data is written and no `stage_done` is pulsed.
- No arithmetic is performed. Data passes through bit-exact.

## Timing
- Reset values:
  - State IDLE, `s` = 0, latched stage count = 1.
  - Bank all zeros, so `output_real`/`output_imag` = 0.
  - `vec_ready` = 0, `stage_done` = 0, `stage_idx` = 0, `out_valid` = 0.
- `vec_ready` is a registered function of state. It rises the cycle after `start`.
- The bank is updated on the accepting edge and is visible on `output_*` the following cycle.
- `stage_done` is registered and asserts the cycle after the accepting edge.
- Latency: `out_valid` rises 1 cycle after the final accepted beat, in the same cycle as its `stage_done`.
- Throughput: one beat per cycle in COLLECT. Back-to-back transforms need 1 IDLE cycle plus a `start`.
- Reset asserted mid-transform returns all state to reset values immediately. Outputs are zero while `rst` is low.

## Structure
- Shared package `fft_pkg`:
  - `NUM_VEC` = 8, `NUM_LANE` = 4, `NUM_PT` = 32.
  - Stage encoding constants.
  - Function `stage_index(stage, v, j)` returning idx.
  - The input redistribution side uses the same function, so the permutation is defined in one place.
- Sub-module `collector_bank`: 32×2 registers of formatWidth bits with a one-beat parallel write port. It takes a stage select and the 8 vector words, contains the index map, and drives the packed outputs.
- Top level: FSM, stage counter and handshakes.

## Test plan
1. Reset: hold `rst` = 0, then release. All outputs are 0 and the state is IDLE. Toggling `vec_valid` in IDLE causes no write and no `stage_done`.
2. Single stage: `num_stages` = 1, one beat with lane value = 8j + v. One cycle later `out_valid` = 1 and element n = n for all 32 elements, real and imaginary.
3. Three stages: beats 0 and 1 carry junk, beat 2 has vector v lane j = 4v + j. `stage_idx` pulses 0, 1, 2. The output has element n = n.
4. Backpressure: hold `out_ready` = 0 for 5 cycles. Output is stable, `vec_ready` = 0, and an extra `vec_valid` is ignored. When `out_ready` = 1, `out_valid` drops the next cycle and the state is IDLE.
5. Abort: `start` in the same cycle as a stage-1 beat. The beat is discarded, `stage_idx` restarts at 0, and `out_valid` never rises for the aborted transform.
6. Async reset mid-COLLECT, after 1 of 3 beats: outputs clear immediately. After `rst` = 1 and a new `start`, a full 2-stage transform completes correctly.
